aes_decipher_arbiter: RTL and testbench

//  Shares one aes_decipher_block between two independent requesters (e.g. a bus

---
 rtl/aes_decipher_arbiter.sv | 103 ++++++++++
 tb/tb_aes_decipher_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_arbiter.sv
// Two-requester front end for a single aes_decipher_block: arbitrates block
// requests, sequences the core's next/ready handshake and returns tagged results.
//
// state | meaning
// IDLE  | core free; grant to a requester when core_ready and a request is present
// START | one-cycle core_next pulse and ack to the granted requester
// WAIT  | core working; leave on core_ready and publish the result
module aes_decipher_arbiter #(
  parameter logic FIXED_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         keylen0,
  input  logic [127:0] block0,
  output logic         ack0,
  input  logic         req1,
  input  logic         keylen1,
  input  logic [127:0] block1,
  output logic         ack1,
  output logic [127:0] result,
  output logic         result_valid,
  output logic         result_id,
  output logic         busy,
  output logic         core_next,
  output logic         core_keylen,
  output logic [127:0] core_block,
  input  logic         core_ready,
  input  logic [127:0] core_result,
  output logic         key_sel
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t state, state_nx;
  logic   last_grant;
  logic   grant_go;
  logic   winner;
  logic   done;

  always_comb begin
    state_nx = state;
    grant_go = 1'b0;
    winner   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (core_ready && (req0 || req1)) begin
          grant_go = 1'b1;
          state_nx = START;
          // Contention: fixed priority favours 0, otherwise the loser of the last grant wins.
          if (req0 && req1) winner = FIXED_PRIO ? 1'b0 : ~last_grant;
          else              winner = req1;
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (core_ready) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      key_sel      <= 1'b0;
      core_block   <= '0;
      core_keylen  <= 1'b0;
      busy         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      core_next    <= 1'b0;
      result       <= '0;
      result_id    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      ack0         <= grant_go && !winner;
      ack1         <= grant_go && winner;
      core_next    <= grant_go;
      result_valid <= done;
      if (grant_go) begin
        core_block  <= winner ? block1 : block0;
        core_keylen <= winner ? keylen1 : keylen0;
        key_sel     <= winner;
        last_grant  <= winner;
        busy        <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (done) begin
        result    <= core_result;
        result_id <= key_sel;
      end
    end
  end

endmodule

// File: tb/tb_aes_decipher_arbiter.sv
// Directed bench: round-robin instance (idx 0) and fixed-priority instance (idx 1),
// each driving a behavioural core model with a two-slot round-key memory.
module tb_aes_decipher_arbiter;

  localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY0    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1    = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] B0      = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] B1      = 128'hdeadbeefcafef00d1122334455667788;
  localparam logic [127:0] B2      = 128'h00000000ffffffff00000000ffffffff;
  localparam logic [127:0] B3      = 128'h13579bdf2468ace013579bdf2468ace0;
  localparam logic [127:0] B4      = 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a;
  localparam logic [127:0] B5      = 128'h8000000000000000000000000000_0001;
  localparam int           CORE_LAT = 50;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req0[2], keylen0[2], req1[2], keylen1[2];
  logic [127:0] block0[2], block1[2];
  logic         ack0[2], ack1[2], result_valid[2], result_id[2], busy[2];
  logic         core_next[2], core_keylen[2], core_ready[2], key_sel[2];
  logic [127:0] result[2], core_block[2], core_result[2];
  logic         m_ready[2];
  int           m_cnt[2];
  logic         hold_off;
  int           total = 0;
  int           bad   = 0;
  int           viol  = 0;

  always #5 clk = ~clk;

  aes_decipher_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[0]), .keylen0(keylen0[0]), .block0(block0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .keylen1(keylen1[0]), .block1(block1[0]), .ack1(ack1[0]),
    .result(result[0]), .result_valid(result_valid[0]), .result_id(result_id[0]),
    .busy(busy[0]), .core_next(core_next[0]), .core_keylen(core_keylen[0]),
    .core_block(core_block[0]), .core_ready(core_ready[0]),
    .core_result(core_result[0]), .key_sel(key_sel[0]));

  aes_decipher_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset_n(reset_n),
    .req0(req0[1]), .keylen0(keylen0[1]), .block0(block0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .keylen1(keylen1[1]), .block1(block1[1]), .ack1(ack1[1]),
    .result(result[1]), .result_valid(result_valid[1]), .result_id(result_id[1]),
    .busy(busy[1]), .core_next(core_next[1]), .core_keylen(core_keylen[1]),
    .core_block(core_block[1]), .core_ready(core_ready[1]),
    .core_result(core_result[1]), .key_sel(key_sel[1]));

  // Known-answer vector for key slot 0, otherwise a keyed scramble that exposes block/keylen/slot.
  function automatic logic [127:0] core_fn(input logic [127:0] blk, input logic kl, input logic ks);
    logic [127:0] key;
    key = ks ? KEY1 : KEY0;
    if (blk == KAT_CT && !kl && key == KEY0) return KAT_PT;
    return blk ^ key ^ {127'b0, kl};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_ready[i]     <= 1'b1;
        m_cnt[i]       <= 0;
        core_result[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (core_next[i]) begin
          m_ready[i] <= 1'b0;
          m_cnt[i]   <= CORE_LAT;
        end else if (!m_ready[i]) begin
          if (m_cnt[i] == 0) begin
            m_ready[i]     <= 1'b1;
            core_result[i] <= core_fn(core_block[i], core_keylen[i], key_sel[i]);
          end else begin
            m_cnt[i] <= m_cnt[i] - 1;
          end
        end
      end
    end
  end

  assign core_ready[0] = m_ready[0] & ~hold_off;
  assign core_ready[1] = m_ready[1];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      if ((ack0[i] && ack1[i]) || (result_valid[i] && core_next[i])) viol <= viol + 1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 ack0, 1 ack1, 2 result_valid, 3 either ack
  function automatic logic cond(input int inst, input int kind);
    case (kind)
      0:       return ack0[inst];
      1:       return ack1[inst];
      2:       return result_valid[inst];
      default: return ack0[inst] | ack1[inst];
    endcase
  endfunction

  task automatic wait_for(input string tag, input int inst, input int kind, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(inst, kind) && n < 200);
    chk1(tag, cond(inst, kind), 1'b1);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0;
    end
    hold_off = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n, early_ack, not_busy, flag;
    for (int i = 0; i < 2; i++) begin
      req0[i] = 1'b0; req1[i] = 1'b0; keylen0[i] = 1'b0; keylen1[i] = 1'b0;
      block0[i] = '0; block1[i] = '0;
    end
    hold_off = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst_ack0", ack0[0], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_key_sel", key_sel[0], 1'b0);
    chk("rst_result", result[0], '0);
    chk("rst_core_block", core_block[0], '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk1("idle_core_next", core_next[0], 1'b0);
    chk1("idle_rv", result_valid[0], 1'b0);

    // Single AES-128 known-answer job with latency check
    req0[0] = 1'b1; block0[0] = KAT_CT; keylen0[0] = 1'b0;
    @(negedge clk);
    chk1("t1_ack0", ack0[0], 1'b1);
    chk1("t1_ack1", ack1[0], 1'b0);
    chk1("t1_core_next", core_next[0], 1'b1);
    chk1("t1_busy", busy[0], 1'b1);
    chk("t1_core_block", core_block[0], KAT_CT);
    req0[0] = 1'b0;
    @(negedge clk);
    chk1("t1_ack0_pulse", ack0[0], 1'b0);
    chk1("t1_next_pulse", core_next[0], 1'b0);
    wait_for("t1_wait_rv", 0, 2, n);
    chki("t1_latency", n, 52);
    chk("t1_result", result[0], KAT_PT);
    chk1("t1_result_id", result_id[0], 1'b0);
    chk1("t1_busy_low", busy[0], 1'b0);
    @(negedge clk);
    chk1("t1_rv_pulse", result_valid[0], 1'b0);
    chk("t1_result_held", result[0], KAT_PT);

    // Round-robin contention from reset
    do_reset();
    req0[0] = 1'b1; block0[0] = B0; keylen0[0] = 1'b0;
    req1[0] = 1'b1; block1[0] = B1; keylen1[0] = 1'b1;
    @(negedge clk);
    chk1("t2_first_ack0", ack0[0], 1'b1);
    chk1("t2_first_ack1", ack1[0], 1'b0);
    req0[0] = 1'b0;
    wait_for("t2_wait_rv0", 0, 2, n);
    chk("t2_result0", result[0], B0 ^ KEY0);
    chk1("t2_id0", result_id[0], 1'b0);
    @(negedge clk);
    chk1("t2_ack1_after_rv", ack1[0], 1'b1);
    req1[0] = 1'b0;
    wait_for("t2_wait_rv1", 0, 2, n);
    chk("t2_result1", result[0], B1 ^ KEY1 ^ 128'd1);
    chk1("t2_id1", result_id[0], 1'b1);
    req0[0] = 1'b1; req1[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_for("t2_wait_ack", 0, 3, n);
      chk1("t2_rr_order", ack1[0], logic'(k % 2));
      if (k == 3) begin
        req0[0] = 1'b0; req1[0] = 1'b0;
      end
      wait_for("t2_wait_rv", 0, 2, n);
      chk1("t2_rr_id", result_id[0], logic'(k % 2));
      chk("t2_rr_result", result[0], (k % 2) ? (B1 ^ KEY1 ^ 128'd1) : (B0 ^ KEY0));
    end

    // Request arriving during WAIT is held off until the core frees up
    req0[0] = 1'b1; block0[0] = B2; keylen0[0] = 1'b0;
    wait_for("t4_wait_ack0", 0, 0, n);
    req0[0] = 1'b0;
    repeat (5) @(negedge clk);
    req1[0] = 1'b1; block1[0] = B3; keylen1[0] = 1'b0;
    early_ack = 0; not_busy = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!result_valid[0]) begin
        if (ack1[0]) early_ack++;
        if (!busy[0]) not_busy++;
      end
    end while (!result_valid[0] && n < 200);
    chk1("t4_rv_seen", result_valid[0], 1'b1);
    chk("t4_result", result[0], B2 ^ KEY0);
    chki("t4_early_ack1", early_ack, 0);
    chki("t4_busy_drop", not_busy, 0);
    @(negedge clk);
    chk1("t4_ack1", ack1[0], 1'b1);
    req1[0] = 1'b0;
    wait_for("t4_wait_rv1", 0, 2, n);
    chk("t4_result1", result[0], B3 ^ KEY1);

    // Core not ready: no grant until ready returns
    hold_off = 1'b1;
    req0[0] = 1'b1; block0[0] = B4; keylen0[0] = 1'b0;
    flag = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0[0] || core_next[0] || busy[0]) flag++;
    end
    chki("t5_no_grant", flag, 0);
    hold_off = 1'b0;
    @(negedge clk);
    chk1("t5_ack0", ack0[0], 1'b1);
    chk1("t5_core_next", core_next[0], 1'b1);
    req0[0] = 1'b0;
    wait_for("t5_wait_rv", 0, 2, n);
    chk("t5_result", result[0], B4 ^ KEY0);

    // Reset in the middle of WAIT aborts the job
    req0[0] = 1'b1; block0[0] = B5; keylen0[0] = 1'b0;
    @(negedge clk);
    chk1("t6_ack0", ack0[0], 1'b1);
    req0[0] = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk1("t6_busy", busy[0], 1'b0);
    chk1("t6_key_sel", key_sel[0], 1'b0);
    chk1("t6_rv", result_valid[0], 1'b0);
    chk("t6_result", result[0], '0);
    chk("t6_core_block", core_block[0], '0);
    @(negedge clk);
    reset_n = 1'b1;
    flag = 0;
    repeat (60) begin
      @(negedge clk);
      if (result_valid[0] || ack0[0] || ack1[0]) flag++;
    end
    chki("t6_no_stray", flag, 0);
    req0[0] = 1'b1; block0[0] = KAT_CT; keylen0[0] = 1'b0;
    wait_for("t6_wait_ack0", 0, 0, n);
    chki("t6_ack_latency", n, 1);
    req0[0] = 1'b0;
    wait_for("t6_wait_rv", 0, 2, n);
    chk("t6_result_after", result[0], KAT_PT);
    chk1("t6_id_after", result_id[0], 1'b0);

    // Fixed priority: requester 0 starves requester 1 while it keeps asking
    req0[1] = 1'b1; block0[1] = B0; keylen0[1] = 1'b0;
    req1[1] = 1'b1; block1[1] = B1; keylen1[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for("t3_wait_ack", 1, 3, n);
      chk1("t3_fp_ack0", ack0[1], 1'b1);
      chk1("t3_fp_ack1", ack1[1], 1'b0);
      if (k == 2) req0[1] = 1'b0;
      wait_for("t3_wait_rv", 1, 2, n);
      chk("t3_fp_result", result[1], B0 ^ KEY0);
    end
    wait_for("t3_wait_ack1", 1, 3, n);
    chk1("t3_ack1_after_drop", ack1[1], 1'b1);
    chki("t3_ack1_latency", n, 1);
    req1[1] = 1'b0;
    wait_for("t3_wait_rv1", 1, 2, n);
    chk("t3_result1", result[1], B1 ^ KEY1 ^ 128'd1);
    chk1("t3_id1", result_id[1], 1'b1);

    @(negedge clk);
    chki("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
